sbst_bist_ctrl: RTL and testbench
=================================

Name: sbst_bist_ctrl

Overview:
Self-test controller inside the RI5CY wrapper. It consumes the testbench start strobe and produces the test_o / go_nogo status pair that the bench polls before it loads firmware. On launch it streams LFSR pseudo-random patterns to the circuit under test (CUT) and compacts the CUT responses in a MISR. The final signature is compared to a golden value to give a go/no-go verdict.

Parameters:
DATA_WIDTH, 32, pattern/response/signature width
N_PATTERNS, 1024, patterns issued per run (>=1)
MAX_OUTSTANDING, 4, max issued-but-unanswered patterns
LFSR_SEED, 32'hACE1_2468, LFSR load value at launch (nonzero)
LFSR_POLY, 32'h8020_0003, Galois LFSR feedback taps
MISR_POLY, 32'h04C1_1DB7, MISR feedback taps
GOLDEN_SIG, 32'h0000_0000, expected final signature
TIMEOUT, 64, idle cycles tolerated before a run is failed

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
start_test_i  in  1  launch request; a 1->0 transition starts a run
test_o  out  1  1 = test pending/running, 0 = verdict valid
go_nogo_o  out  1  1 = pass; valid only while test_o=0
cut_sel_o  out  1  steers the CUT into test mode; high in RUN/DRAIN
pat_valid_o  out  1  pattern valid
pat_ready_i  in  1  CUT accepts pattern
pat_data_o  out  DATA_WIDTH  pattern word
rsp_valid_i  in  1  CUT response valid (no backpressure)
rsp_data_i  in  DATA_WIDTH  CUT response word
signature_o  out  DATA_WIDTH  current MISR value (debug)

Behaviour:
- Reset values: test_o=1, go_nogo_o=0, cut_sel_o=0, pat_valid_o=0, pat_data_o=0, signature_o=0. State=IDLE, start_q=0, all counters=0.
- Launch edge: start_q registers start_test_i. launch = start_q & ~start_test_i, honoured only in IDLE or DONE. A start held low straight out of reset never launches.
- States: IDLE, RUN, DRAIN, COMPARE, DONE.
- Transitions:
  - IDLE/DONE -> RUN on launch. In the same edge: lfsr<=LFSR_SEED, misr<=0, pat_cnt, rsp_cnt and timer cleared, err<=0, test_o<=1, go_nogo_o<=0.
  - RUN -> DRAIN when the accept that makes pat_cnt==N_PATTERNS occurs.
  - DRAIN -> COMPARE on the edge after rsp_cnt reaches N_PATTERNS.
  - COMPARE -> DONE after one cycle. On that edge: go_nogo_o<=(misr==GOLDEN_SIG)&&!err, and test_o<=0.
  - RUN/DRAIN -> DONE when timer==TIMEOUT. On that edge: go_nogo_o<=0, test_o<=0.
- Pattern handshake:
  - pat_valid_o=1 in RUN when (pat_cnt-rsp_cnt)<MAX_OUTSTANDING and pat_cnt<N_PATTERNS.
  - pat_data_o=lfsr. Once valid is asserted, valid and data hold until accepted.
  - Accept = pat_valid_o & pat_ready_i. On accept: pat_cnt++ and lfsr advances: lfsr<={lfsr[W-2:0],1'b0} ^ (lfsr[W-1] ? LFSR_POLY : 0).
  - The first pattern issued equals LFSR_SEED.
- Responses:
  - rsp_valid_i is accepted only in RUN/DRAIN and ignored elsewhere.
  - On accept: misr<={misr[W-2:0],1'b0} ^ (misr[W-1] ? MISR_POLY : 0) ^ rsp_data_i, and rsp_cnt++.
  - A response arriving when rsp_cnt==pat_cnt (unsolicited) sets err and is not compacted.
- Simultaneous pattern accept and response: both counted in the same cycle; outstanding count unchanged.
- Timer: cleared on any pattern accept or response; otherwise increments in RUN/DRAIN; saturates at TIMEOUT.
- start_test_i edges during RUN/DRAIN/COMPARE are ignored.
- DONE: verdict held until the next launch or reset.
- rst_i asserted mid-run: abort immediately to reset values (test_o=1, go_nogo_o=0); the next launch still requires a 1->0 edge.
- Counters are sized $clog2(N_PATTERNS+1) bits and never wrap.

Test Plan:
- Echo CUT (rsp_data_i=pat_data_o, latency 1, pat_ready_i=1), N_PATTERNS=4, GOLDEN_SIG set from the model. Launch sampled at edge 0 -> patterns accepted at edges 1-4, first word 32'hACE1_2468, responses at edges 2-5, test_o=0 from edge 7, go_nogo_o=1.
- Same setup, rsp_data_i bit 0 flipped on the third response -> signature_o differs from the model, go_nogo_o=0, test_o=0.
- Hold pat_ready_i=0 for 10 cycles after launch -> pat_valid_o=1 with pat_data_o stable at 32'hACE1_2468 throughout; the run then completes normally.
- CUT never answers, TIMEOUT=8 -> exactly MAX_OUTSTANDING=4 patterns issued, then pat_valid_o=0; test_o falls 8 idle cycles later with go_nogo_o=0.
- rsp_valid_i pulsed before any pattern is issued -> err set, final go_nogo_o=0. rsp_valid_i pulsed while in IDLE -> no effect.
- Assert rst_i in RUN mid-stream -> next edge test_o=1, go_nogo_o=0, pat_valid_o=0. A fresh 1->0 start edge then gives a full pass run.

Source files
------------

// File: rtl/sbst_bist_ctrl.sv
// -----------------------------------------------------------------------------
// sbst_bist_ctrl
//
// Self-test controller for the RI5CY wrapper. A 1->0 edge on start_test_i
// launches a run: LFSR patterns are streamed to the circuit under test, its
// responses are compacted in a MISR, and the final signature is compared with
// GOLDEN_SIG to give a go/no-go verdict. A run that stalls for TIMEOUT cycles
// is failed.
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous reset, active high
//   start_test_i  launch request (1->0 edge starts a run in IDLE/DONE)
//   test_o        1 = test pending/running, 0 = verdict valid
//   go_nogo_o     1 = pass, valid only while test_o = 0
//   cut_sel_o     CUT test-mode select, high in RUN/DRAIN
//   pat_valid_o   pattern valid
//   pat_ready_i   CUT accepts pattern
//   pat_data_o    pattern word (current LFSR state)
//   rsp_valid_i   CUT response valid (no backpressure)
//   rsp_data_i    CUT response word
//   signature_o   current MISR value (debug)
// -----------------------------------------------------------------------------
module sbst_bist_ctrl #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    N_PATTERNS      = 1024,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED       = 32'hACE1_2468,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY       = 32'h8020_0003,
    parameter logic [DATA_WIDTH-1:0] MISR_POLY       = 32'h04C1_1DB7,
    parameter logic [DATA_WIDTH-1:0] GOLDEN_SIG      = 32'h0000_0000,
    parameter int                    TIMEOUT         = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_test_i,
    output logic                  test_o,
    output logic                  go_nogo_o,
    output logic                  cut_sel_o,
    output logic                  pat_valid_o,
    input  logic                  pat_ready_i,
    output logic [DATA_WIDTH-1:0] pat_data_o,
    input  logic                  rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] rsp_data_i,
    output logic [DATA_WIDTH-1:0] signature_o
);

    localparam int CW = $clog2(N_PATTERNS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    // Outstanding count can never exceed N_PATTERNS, so clamp the limit to
    // keep it representable in the counter width.
    localparam int MAX_LIM = (MAX_OUTSTANDING > N_PATTERNS) ? N_PATTERNS : MAX_OUTSTANDING;

    localparam logic [CW-1:0] N_C       = CW'(N_PATTERNS);
    localparam logic [CW-1:0] N_LAST_C  = CW'(N_PATTERNS - 1);
    localparam logic [CW-1:0] MAX_C     = CW'(MAX_LIM);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_start_q;
    logic [DATA_WIDTH-1:0] r_lfsr;
    logic [DATA_WIDTH-1:0] r_misr;
    logic [CW-1:0]         r_pat_cnt;
    logic [CW-1:0]         r_rsp_cnt;
    logic [TW-1:0]         r_timer;
    logic                  r_err;
    logic                  r_test;
    logic                  r_go;

    logic                  w_launch;
    logic                  w_active;
    logic [CW-1:0]         w_outstanding;
    logic                  w_pat_valid;
    logic                  w_pat_acc;
    logic                  w_rsp_acc;
    logic                  w_rsp_ok;
    logic                  w_timeout;
    logic                  w_cut_sel;

    assign w_launch      = r_start_q & ~start_test_i & ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_active      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_outstanding = r_pat_cnt - r_rsp_cnt;
    // Valid depends only on registered state, so once raised it holds until
    // the accept (or a timeout leaves RUN).
    assign w_pat_valid   = (r_state == S_RUN) && (w_outstanding < MAX_C) && (r_pat_cnt < N_C);
    assign w_pat_acc     = w_pat_valid & pat_ready_i;
    assign w_rsp_acc     = w_active & rsp_valid_i;
    // A response with nothing outstanding is unsolicited: flagged, not compacted.
    assign w_rsp_ok      = w_rsp_acc & (r_rsp_cnt != r_pat_cnt);
    assign w_timeout     = w_active & (r_timer == TIMEOUT_C);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: defaults assigned first so every path drives every signal and
        // no latch is inferred.
        w_state_next = r_state;
        w_cut_sel    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_launch) w_state_next = S_RUN;
            end
            S_RUN: begin
                w_cut_sel = 1'b1;
                if (w_timeout)                                  w_state_next = S_DONE;
                else if (w_pat_acc && (r_pat_cnt == N_LAST_C))  w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_cut_sel = 1'b1;
                if (w_timeout)              w_state_next = S_DONE;
                else if (r_rsp_cnt == N_C)  w_state_next = S_COMPARE;
            end
            S_COMPARE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_start_q <= 1'b0;
            r_lfsr    <= '0;
            r_misr    <= '0;
            r_pat_cnt <= '0;
            r_rsp_cnt <= '0;
            r_timer   <= '0;
            r_err     <= 1'b0;
            r_test    <= 1'b1;
            r_go      <= 1'b0;
        end else begin
            r_start_q <= start_test_i;
            if (w_launch) begin
                r_lfsr    <= LFSR_SEED;
                r_misr    <= '0;
                r_pat_cnt <= '0;
                r_rsp_cnt <= '0;
                r_timer   <= '0;
                r_err     <= 1'b0;
                r_test    <= 1'b1;
                r_go      <= 1'b0;
            end else begin
                if (w_pat_acc) begin
                    r_pat_cnt <= r_pat_cnt + CW'(1);
                    r_lfsr    <= {r_lfsr[DATA_WIDTH-2:0], 1'b0} ^ (r_lfsr[DATA_WIDTH-1] ? LFSR_POLY : '0);
                end
                if (w_rsp_ok) begin
                    r_rsp_cnt <= r_rsp_cnt + CW'(1);
                    r_misr    <= {r_misr[DATA_WIDTH-2:0], 1'b0} ^ (r_misr[DATA_WIDTH-1] ? MISR_POLY : '0)
                                 ^ rsp_data_i;
                end
                if (w_rsp_acc && !w_rsp_ok) begin
                    r_err <= 1'b1;
                end

                // Any handshake activity restarts the idle timer; it saturates.
                if (w_pat_acc || w_rsp_acc) begin
                    r_timer <= '0;
                end else if (w_active && (r_timer != TIMEOUT_C)) begin
                    r_timer <= r_timer + TW'(1);
                end

                if (w_timeout) begin
                    r_test <= 1'b0;
                    r_go   <= 1'b0;
                end else if (r_state == S_COMPARE) begin
                    r_test <= 1'b0;
                    r_go   <= (r_misr == GOLDEN_SIG) && !r_err;
                end
            end
        end
    end

    assign test_o      = r_test;
    assign go_nogo_o   = r_go;
    assign cut_sel_o   = w_cut_sel;
    assign pat_valid_o = w_pat_valid;
    assign pat_data_o  = r_lfsr;
    assign signature_o = r_misr;

endmodule

// File: tb/tb_sbst_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sbst_bist_ctrl
//
// Directed bench for sbst_bist_ctrl. Instance A (N_PATTERNS=4, TIMEOUT=64,
// golden signature from a reference model) is driven by an echo CUT with one
// cycle of latency. Instance B (N_PATTERNS=8, TIMEOUT=8) shares clock, reset
// and start, always accepts patterns and never answers.
// -----------------------------------------------------------------------------
module tb_sbst_bist_ctrl;

    localparam logic [31:0] SEED  = 32'hACE1_2468;
    localparam logic [31:0] LPOLY = 32'h8020_0003;
    localparam logic [31:0] MPOLY = 32'h04C1_1DB7;

    // Reference signature of the 4-pattern echo run; flip_idx (1-based)
    // selects a response whose bit 0 is inverted, 0 = none.
    function automatic logic [31:0] model_sig(input int flip_idx);
        logic [31:0] l;
        logic [31:0] m;
        logic [31:0] r;
        l = SEED;
        m = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            r = l ^ ((i == flip_idx) ? 32'd1 : 32'd0);
            m = {m[30:0], 1'b0} ^ (m[31] ? MPOLY : 32'h0) ^ r;
            l = {l[30:0], 1'b0} ^ (l[31] ? LPOLY : 32'h0);
        end
        return m;
    endfunction

    localparam logic [31:0] GOLDEN_A = model_sig(0);

    logic        clk;
    logic        rst_i;
    logic        start_test_i;
    logic        pat_ready_i;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        test_o, go_nogo_o, cut_sel_o, pat_valid_o;
    logic [31:0] pat_data_o, signature_o;

    logic        ready_b, rsp_valid_b;
    logic [31:0] rsp_data_b;
    logic        test_b, go_b, cut_b, valid_b;
    logic [31:0] data_b, sig_b;

    sbst_bist_ctrl #(
        .DATA_WIDTH(32), .N_PATTERNS(4), .MAX_OUTSTANDING(4),
        .LFSR_SEED(SEED), .LFSR_POLY(LPOLY), .MISR_POLY(MPOLY),
        .GOLDEN_SIG(GOLDEN_A), .TIMEOUT(64)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_i), .start_test_i(start_test_i),
        .test_o(test_o), .go_nogo_o(go_nogo_o), .cut_sel_o(cut_sel_o),
        .pat_valid_o(pat_valid_o), .pat_ready_i(pat_ready_i), .pat_data_o(pat_data_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .signature_o(signature_o)
    );

    sbst_bist_ctrl #(
        .DATA_WIDTH(32), .N_PATTERNS(8), .MAX_OUTSTANDING(4),
        .LFSR_SEED(SEED), .LFSR_POLY(LPOLY), .MISR_POLY(MPOLY),
        .GOLDEN_SIG(32'h0), .TIMEOUT(8)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_i), .start_test_i(start_test_i),
        .test_o(test_b), .go_nogo_o(go_b), .cut_sel_o(cut_b),
        .pat_valid_o(valid_b), .pat_ready_i(ready_b), .pat_data_o(data_b),
        .rsp_valid_i(rsp_valid_b), .rsp_data_i(rsp_data_b), .signature_o(sig_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        pend_v   = 1'b0;
    logic [31:0] pend_d   = 32'h0;
    int          rsp_idx  = 0;
    int          flip_at  = 0;
    int          issued_b = 0;

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_test;
        logic        exp_go;
        logic        exp_cut;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a clock edge: drives inputs for the next edge (the
    // echo CUT returns the word accepted on the previous edge), then waits
    // for that edge and returns 1 time unit after it.
    task automatic step(input logic start, input logic ready, input logic echo, input logic extra);
        logic flip;
        flip = 1'b0;
        if (echo && pend_v) begin
            rsp_idx++;
            flip = (rsp_idx == flip_at);
        end
        start_test_i = start;
        pat_ready_i  = ready;
        rsp_valid_i  = (echo & pend_v) | extra;
        rsp_data_i   = pend_d ^ (flip ? 32'd1 : 32'd0);
        #1;
        pend_v = pat_valid_o & pat_ready_i;
        pend_d = pat_data_o;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic ready);
        step(1'b1, ready, 1'b1, 1'b0);
        step(1'b0, ready, 1'b1, 1'b0);
        rsp_idx = 0;
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && test_o; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        check("done_within_budget", {31'b0, test_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                 start ready test go   cut   valid chk   data
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hACE1_2468};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD9E2_48D3};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33E4_91A5};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h67C9_234A};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        rst_i = 1'b1; start_test_i = 1'b0; pat_ready_i = 1'b1;
        rsp_valid_i = 1'b0; rsp_data_i = 32'h0;
        ready_b = 1'b1; rsp_valid_b = 1'b0; rsp_data_b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_test",   {31'b0, test_o},      32'd1);
        check("rst_go",     {31'b0, go_nogo_o},   32'd0);
        check("rst_cut",    {31'b0, cut_sel_o},   32'd0);
        check("rst_valid",  {31'b0, pat_valid_o}, 32'd0);
        check("rst_data",   pat_data_o,           32'h0);
        check("rst_sig",    signature_o,          32'h0);
        check("rst_b_test", {31'b0, test_b},      32'd1);
        rst_i = 1'b0;

        // Response in IDLE is ignored.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("idle_rsp_sig",  signature_o,        32'h0);
        check("idle_rsp_test", {31'b0, test_o},    32'd1);
        check("idle_rsp_cut",  {31'b0, cut_sel_o}, 32'd0);

        // Start held low from reset, then 1->0 launch and full echo pass run.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].start, tbl[i].ready, 1'b1, 1'b0);
            check($sformatf("row%0d_test", i),  {31'b0, test_o},      {31'b0, tbl[i].exp_test});
            check($sformatf("row%0d_go", i),    {31'b0, go_nogo_o},   {31'b0, tbl[i].exp_go});
            check($sformatf("row%0d_cut", i),   {31'b0, cut_sel_o},   {31'b0, tbl[i].exp_cut});
            check($sformatf("row%0d_valid", i), {31'b0, pat_valid_o}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].chk_data) check($sformatf("row%0d_data", i), pat_data_o, tbl[i].exp_data);
        end
        check("pass_sig", signature_o, GOLDEN_A);

        // Response in DONE is ignored and the verdict holds.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("done_rsp_sig",  signature_o,        GOLDEN_A);
        check("done_rsp_go",   {31'b0, go_nogo_o}, 32'd1);
        check("done_rsp_test", {31'b0, test_o},    32'd0);

        // Corrupted third response.
        flip_at = 3;
        launch(1'b1);
        run_to_done(40);
        flip_at = 0;
        check("flip_sig",  signature_o,        model_sig(3));
        check("flip_go",   {31'b0, go_nogo_o}, 32'd0);
        check("flip_test", {31'b0, test_o},    32'd0);

        // CUT stalls pattern acceptance for 10 cycles.
        launch(1'b0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("stall%0d_valid", k), {31'b0, pat_valid_o}, 32'd1);
            check($sformatf("stall%0d_data", k),  pat_data_o,           SEED);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        run_to_done(40);
        check("stall_go",  {31'b0, go_nogo_o}, 32'd1);
        check("stall_sig", signature_o,        GOLDEN_A);

        // Instance B: CUT never answers, TIMEOUT=8.
        repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0);
        launch(1'b1);
        check("tmo_first_data", data_b, SEED);
        for (int e = 1; e <= 13; e++) begin
            if (valid_b) issued_b++;
            step(1'b0, 1'b1, 1'b1, 1'b0);
            check($sformatf("tmo_edge%0d_test", e), {31'b0, test_b}, (e < 13) ? 32'd1 : 32'd0);
            if (e >= 4 && e < 13) check($sformatf("tmo_edge%0d_valid", e), {31'b0, valid_b}, 32'd0);
        end
        check("tmo_issued", issued_b,        32'd4);
        check("tmo_go",     {31'b0, go_b},   32'd0);
        check("tmo_cut",    {31'b0, cut_b},  32'd0);
        check("tmo_sig",    sig_b,           32'h0);

        // Unsolicited response before the first pattern is issued.
        launch(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        run_to_done(40);
        check("unsol_go",  {31'b0, go_nogo_o}, 32'd0);
        check("unsol_sig", signature_o,        GOLDEN_A);

        // Reset mid-run, start low afterwards, then a fresh launch.
        launch(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        rst_i = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        rst_i = 1'b0;
        check("abort_test",  {31'b0, test_o},      32'd1);
        check("abort_go",    {31'b0, go_nogo_o},   32'd0);
        check("abort_valid", {31'b0, pat_valid_o}, 32'd0);
        check("abort_cut",   {31'b0, cut_sel_o},   32'd0);
        check("abort_sig",   signature_o,          32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("abort_nolaunch_valid", {31'b0, pat_valid_o}, 32'd0);
        check("abort_nolaunch_sig",   signature_o,          32'h0);
        launch(1'b1);
        run_to_done(40);
        check("rerun_go",  {31'b0, go_nogo_o}, 32'd1);
        check("rerun_sig", signature_o,        GOLDEN_A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
